// File: rtl/reminder_scheduler.sv
// Medicine reminder scheduler: on each Tick, scans a 16-entry frequency RAM,
// ages per-medicine counters and raises an acknowledgeable alert for each due medicine.
module reminder_scheduler (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       Ack,
    input  logic [3:0] RdData,
    output logic       Read_En,
    output logic [3:0] R_Addr,
    output logic       Alert,
    output logic [3:0] AlertMedID,
    output logic       Busy,
    output logic       Overrun
);

    typedef enum logic [1:0] {StIdle, StScan, StFlush} state_e;

    state_e      state;
    logic [3:0]  cnt [16];
    logic [15:0] pending;

    // Delayed copy of the read strobe/address: RdData belongs to eval_id this cycle.
    logic        eval_en;
    logic [3:0]  eval_id;

    logic [3:0]  cnt_next;
    logic        fire;
    logic [15:0] pending_next;
    logic [3:0]  lowest_id;

    always_comb begin
        cnt_next = cnt[eval_id];
        fire     = 1'b0;
        if (RdData == 4'd0) begin
            cnt_next = 4'd0;
        end else if ({1'b0, cnt[eval_id]} + 5'd1 >= {1'b0, RdData}) begin
            cnt_next = 4'd0;
            fire     = 1'b1;
        end else begin
            cnt_next = cnt[eval_id] + 4'd1;
        end
    end

    // Ack clears first so that a same-cycle evaluation set takes priority.
    always_comb begin
        pending_next = pending;
        if (Alert && Ack) begin
            pending_next[AlertMedID] = 1'b0;
        end
        if (eval_en && fire) begin
            pending_next[eval_id] = 1'b1;
        end
    end

    always_comb begin
        lowest_id = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_next[i]) begin
                lowest_id = i[3:0];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= StIdle;
            Read_En    <= 1'b0;
            R_Addr     <= 4'd0;
            Alert      <= 1'b0;
            AlertMedID <= 4'd0;
            Busy       <= 1'b0;
            Overrun    <= 1'b0;
            pending    <= 16'd0;
            eval_en    <= 1'b0;
            eval_id    <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            eval_en    <= Read_En;
            eval_id    <= R_Addr;
            pending    <= pending_next;
            Alert      <= |pending_next;
            AlertMedID <= lowest_id;
            Overrun    <= Tick && (state != StIdle);
            if (eval_en) begin
                cnt[eval_id] <= cnt_next;
            end
            unique case (state)
                StIdle: begin
                    if (Tick) begin
                        state   <= StScan;
                        Read_En <= 1'b1;
                        R_Addr  <= 4'd0;
                        Busy    <= 1'b1;
                    end
                end
                StScan: begin
                    if (R_Addr == 4'd15) begin
                        state   <= StFlush;
                        Read_En <= 1'b0;
                        R_Addr  <= 4'd0;
                    end else begin
                        R_Addr <= R_Addr + 4'd1;
                    end
                end
                StFlush: begin
                    state <= StIdle;
                    Busy  <= 1'b0;
                end
                default: begin
                    state   <= StIdle;
                    Read_En <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
